fetch_inst_queue: RTL and testbench

- Read-side counterpart of the IF1 fetch-packet writer: stores 2-wide fetch packets (pc, prediction, inst0/inst1, icache exception info) in a DEPTH-entry circular buffer.
- Splits each packet into individual instructions and presents up to two in-order instructions per cycle to ID.
- Returns the backpressure flags `fifo_allowin`, `space_ok` and `nearly_full` that the writer's handshake depends on.

---
 rtl/fetch_inst_queue_if.sv | 45 ++++
 rtl/fetch_inst_queue.sv | 144 ++++++++++++++
 tb/tb_fetch_inst_queue.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/fetch_inst_queue_if.sv
// Handshake/data bundle between the IF1 packet writer, the fetch instruction queue and ID.
// slave = queue side, master = writer/ID side.
`ifndef INST_NOP
`define INST_NOP 32'h03400000
`endif

interface fetch_inst_queue_if;
  logic        write_en;
  logic        fifo_allowin;
  logic        space_ok;
  logic        nearly_full;
  logic [31:0] in_pc;
  logic [31:0] in_pc_next;
  logic        in_pc_taken;
  logic [31:0] in_inst0;
  logic [31:0] in_inst1;
  logic [31:0] in_badv;
  logic [6:0]  in_exception;
  logic [1:0]  in_excp_flag;
  logic        id_allowin;
  logic [1:0]  out_valid;
  logic [31:0] out_pc0, out_pc1;
  logic [31:0] out_pc_next0, out_pc_next1;
  logic        out_taken0, out_taken1;
  logic [31:0] out_inst0, out_inst1;
  logic        out_excp0, out_excp1;
  logic [31:0] out_badv;
  logic [6:0]  out_exception;

  modport slave (
    input  write_en, in_pc, in_pc_next, in_pc_taken, in_inst0, in_inst1,
           in_badv, in_exception, in_excp_flag, id_allowin,
    output fifo_allowin, space_ok, nearly_full, out_valid, out_pc0, out_pc1,
           out_pc_next0, out_pc_next1, out_taken0, out_taken1, out_inst0, out_inst1,
           out_excp0, out_excp1, out_badv, out_exception
  );

  modport master (
    output write_en, in_pc, in_pc_next, in_pc_taken, in_inst0, in_inst1,
           in_badv, in_exception, in_excp_flag, id_allowin,
    input  fifo_allowin, space_ok, nearly_full, out_valid, out_pc0, out_pc1,
           out_pc_next0, out_pc_next1, out_taken0, out_taken1, out_inst0, out_inst1,
           out_excp0, out_excp1, out_badv, out_exception
  );
endinterface

// File: rtl/fetch_inst_queue.sv
// Circular buffer of 2-wide fetch packets, split into up to two in-order instructions per cycle for ID.
// A packet is visible the cycle after it is written; flags derive from the pre-update entry count.
module fetch_inst_queue #(
  parameter int DEPTH     = 8,
  parameter int LOG_DEPTH = 3
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              flush,
  fetch_inst_queue_if.slave bus
);
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic        taken;
    logic [31:0] inst0;
    logic [31:0] inst1;
    logic [31:0] badv;
    logic [6:0]  exception;
    logic [1:0]  excp_flag;
    logic        len2;
  } entry_t;

  localparam logic [LOG_DEPTH:0] DEPTH_C = (LOG_DEPTH+1)'(DEPTH);

  entry_t               mem_q [DEPTH];
  logic [LOG_DEPTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd1;
  logic [LOG_DEPTH:0]   count_q, count_d;
  logic                 half_q, half_d;

  entry_t      head;
  logic        allowin, wr_fire, pop0, pop1;
  logic [1:0]  retired;
  logic        last0, h1_last, vld0, vld1, vld1_raw;
  logic [31:0] pc0, pc1, pc_next0, pc_next1, inst0, inst1;
  logic        taken0, taken1, excp0, excp1;

  assign allowin          = (count_q != DEPTH_C);
  assign bus.fifo_allowin = allowin;
  assign bus.space_ok     = (count_q <= DEPTH_C - (LOG_DEPTH+1)'(2));
  assign bus.nearly_full  = (count_q == DEPTH_C - (LOG_DEPTH+1)'(1));
  assign wr_fire          = bus.write_en & allowin;

  // Slot0 is instruction 'half' of the head; slot1 is the head's second word or h1's first.
  always_comb begin
    head     = mem_q[rd_ptr_q];
    rd1      = rd_ptr_q + LOG_DEPTH'(1);
    last0    = half_q | ~head.len2;
    h1_last  = ~mem_q[rd1].len2;
    vld0     = (count_q != '0);
    pc0      = head.pc + {29'd0, half_q, 2'b00};
    inst0    = half_q ? head.inst1 : head.inst0;
    pc_next0 = last0 ? head.pc_next : pc0 + 32'd4;
    taken0   = last0 & head.taken;
    excp0    = head.excp_flag[half_q];
    if (!last0) begin
      vld1_raw = vld0;
      pc1      = head.pc + 32'd4;
      inst1    = head.inst1;
      pc_next1 = head.pc_next;
      taken1   = head.taken;
      excp1    = head.excp_flag[1];
    end else begin
      vld1_raw = (count_q >= (LOG_DEPTH+1)'(2));
      pc1      = mem_q[rd1].pc;
      inst1    = mem_q[rd1].inst0;
      pc_next1 = h1_last ? mem_q[rd1].pc_next : mem_q[rd1].pc + 32'd4;
      taken1   = h1_last & mem_q[rd1].taken;
      excp1    = mem_q[rd1].excp_flag[0];
    end
    // Exceptions and taken branches leave the queue alone.
    vld1 = vld1_raw & vld0 & ~excp0 & ~taken0;
  end

  always_comb begin
    pop0    = bus.id_allowin & vld0;
    pop1    = bus.id_allowin & vld1;
    retired = 2'd0;
    half_d  = half_q;
    if (pop0) begin
      if (!last0) begin
        if (pop1) begin
          retired = 2'd1;
          half_d  = 1'b0;
        end else begin
          half_d  = 1'b1;
        end
      end else begin
        retired = 2'd1;
        half_d  = 1'b0;
        if (pop1) begin
          if (h1_last) retired = 2'd2;
          else         half_d  = 1'b1;
        end
      end
    end
    rd_ptr_d = rd_ptr_q + LOG_DEPTH'(retired);
    wr_ptr_d = wr_ptr_q + LOG_DEPTH'(wr_fire);
    count_d  = count_q + (LOG_DEPTH+1)'(wr_fire) - (LOG_DEPTH+1)'(retired);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      half_q   <= 1'b0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      half_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      half_q   <= half_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire && !flush) begin
      mem_q[wr_ptr_q] <= '{pc: bus.in_pc, pc_next: bus.in_pc_next, taken: bus.in_pc_taken,
                           inst0: bus.in_inst0, inst1: bus.in_inst1, badv: bus.in_badv,
                           exception: bus.in_exception, excp_flag: bus.in_excp_flag,
                           len2: ~bus.in_pc[2]};
    end
  end

  // Invalid slots present zero data and NOP words.
  assign bus.out_valid     = {vld1, vld0};
  assign bus.out_pc0       = vld0 ? pc0 : '0;
  assign bus.out_pc_next0  = vld0 ? pc_next0 : '0;
  assign bus.out_taken0    = vld0 & taken0;
  assign bus.out_inst0     = vld0 ? inst0 : `INST_NOP;
  assign bus.out_excp0     = vld0 & excp0;
  assign bus.out_badv      = vld0 ? head.badv : '0;
  assign bus.out_exception = vld0 ? head.exception : '0;
  assign bus.out_pc1       = vld1 ? pc1 : '0;
  assign bus.out_pc_next1  = vld1 ? pc_next1 : '0;
  assign bus.out_taken1    = vld1 & taken1;
  assign bus.out_inst1     = vld1 ? inst1 : `INST_NOP;
  assign bus.out_excp1     = vld1 & excp1;
endmodule

// File: tb/tb_fetch_inst_queue.sv
// Random + directed stimulus for fetch_inst_queue; a negedge monitor checks the DUT against an
// instruction-level queue model fed by the stimulus process.
module tb_fetch_inst_queue;
  localparam int          DEPTH = 8;
  localparam logic [31:0] NOP   = 32'h03400000;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  fetch_inst_queue_if bus();
  fetch_inst_queue #(.DEPTH(DEPTH), .LOG_DEPTH(3)) dut (
    .clk(clk), .rstn(rstn), .flush(flush), .bus(bus)
  );

  typedef struct {
    logic [31:0] pc, pnext, i0, i1, badv;
    logic        tk;
    logic [6:0]  exc;
    logic [1:0]  ef;
  } pkt_t;

  typedef struct {
    logic [31:0] pc, pnext, inst, badv;
    logic        tk, excp, last;
    logic [6:0]  exc;
  } ins_t;

  ins_t expq[$];
  int   pkt_cnt = 0;
  int   checks  = 0;
  int   errors  = 0;
  int   mon_n;
  ins_t popped;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Expand a packet into its individual instructions.
  task automatic model_push(input pkt_t p);
    int len;
    ins_t e;
    len = p.pc[2] ? 1 : 2;
    for (int k = 0; k < len; k++) begin
      e.pc    = p.pc + 32'(4 * k);
      e.last  = (k == len - 1);
      e.pnext = e.last ? p.pnext : e.pc + 32'd4;
      e.tk    = e.last && p.tk;
      e.inst  = (k == 1) ? p.i1 : p.i0;
      e.excp  = p.ef[k];
      e.badv  = p.badv;
      e.exc   = p.exc;
      expq.push_back(e);
    end
    pkt_cnt++;
  endtask

  function automatic pkt_t mk(input logic [31:0] pc, input logic [31:0] pn,
                              input logic tk, input logic [1:0] ef);
    pkt_t p;
    p.pc    = pc;
    p.pnext = pn;
    p.tk    = tk;
    p.ef    = ef;
    p.i0    = $urandom;
    p.i1    = pc[2] ? NOP : $urandom;
    p.badv  = $urandom;
    p.exc   = 7'($urandom);
    return p;
  endfunction

  function automatic pkt_t rnd_pkt();
    logic [31:0] pc;
    pc = 32'h1c000000 + 32'($urandom_range(0, 1023) * 4);
    return mk(pc, 32'h1c000000 + 32'($urandom_range(0, 1023) * 4),
              ($urandom % 3) == 0, (($urandom % 8) == 0) ? 2'($urandom) : 2'b00);
  endfunction

  task automatic step(input logic we, input pkt_t p, input logic ida, input logic fl);
    logic acc;
    bus.write_en     = we;
    bus.in_pc        = p.pc;
    bus.in_pc_next   = p.pnext;
    bus.in_pc_taken  = p.tk;
    bus.in_inst0     = p.i0;
    bus.in_inst1     = p.i1;
    bus.in_badv      = p.badv;
    bus.in_exception = p.exc;
    bus.in_excp_flag = p.ef;
    bus.id_allowin   = ida;
    flush            = fl;
    acc = we && !fl && rstn && (pkt_cnt < DEPTH);
    @(posedge clk);
    if (fl) begin
      expq.delete();
      pkt_cnt = 0;
    end else if (acc) begin
      model_push(p);
    end
    #1;
  endtask

  task automatic idle(input logic ida);
    step(1'b0, rnd_pkt(), ida, 1'b0);
  endtask

  task automatic async_reset();
    bus.write_en   = 1'b0;
    bus.id_allowin = 1'b0;
    #2 rstn = 1'b0;
    expq.delete();
    pkt_cnt = 0;
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_fifo_allowin", 32'(bus.fifo_allowin), 32'd1);
    chk("rst_space_ok", 32'(bus.space_ok), 32'd1);
    chk("rst_nearly_full", 32'(bus.nearly_full), 32'd0);
    chk("rst_inst0", bus.out_inst0, NOP);
    chk("rst_inst1", bus.out_inst1, NOP);
    chk("rst_pc0", bus.out_pc0, 32'd0);
    chk("rst_badv", bus.out_badv, 32'd0);
    @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  // Monitor: compare the presented slots with the model's queue head, then retire what ID takes.
  always @(negedge clk) begin
    if (expq.size() == 0)                                        mon_n = 0;
    else if (expq.size() >= 2 && !expq[0].excp && !expq[0].tk)   mon_n = 2;
    else                                                         mon_n = 1;
    chk("out_valid", 32'(bus.out_valid), (mon_n == 2) ? 32'd3 : 32'(mon_n));
    if (mon_n >= 1) begin
      chk("pc0", bus.out_pc0, expq[0].pc);
      chk("pc_next0", bus.out_pc_next0, expq[0].pnext);
      chk("taken0", 32'(bus.out_taken0), 32'(expq[0].tk));
      chk("inst0", bus.out_inst0, expq[0].inst);
      chk("excp0", 32'(bus.out_excp0), 32'(expq[0].excp));
      chk("badv", bus.out_badv, expq[0].badv);
      chk("exception", 32'(bus.out_exception), 32'(expq[0].exc));
    end
    if (mon_n == 2) begin
      chk("pc1", bus.out_pc1, expq[1].pc);
      chk("pc_next1", bus.out_pc_next1, expq[1].pnext);
      chk("taken1", 32'(bus.out_taken1), 32'(expq[1].tk));
      chk("inst1", bus.out_inst1, expq[1].inst);
      chk("excp1", 32'(bus.out_excp1), 32'(expq[1].excp));
    end
    chk("fifo_allowin", 32'(bus.fifo_allowin), 32'(pkt_cnt != DEPTH));
    chk("space_ok", 32'(bus.space_ok), 32'(DEPTH - pkt_cnt >= 2));
    chk("nearly_full", 32'(bus.nearly_full), 32'(DEPTH - pkt_cnt == 1));
    if (bus.id_allowin && rstn) begin
      for (int i = 0; i < mon_n; i++) begin
        popped = expq.pop_front();
        if (popped.last) pkt_cnt--;
      end
    end
  end

  initial begin
    bus.write_en   = 1'b0;
    bus.id_allowin = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;

    // Two full-width packets drained by an always-ready ID.
    step(1'b1, mk(32'h1c000000, 32'h1c000008, 1'b0, 2'b00), 1'b1, 1'b0);
    step(1'b1, mk(32'h1c000008, 32'h1c000010, 1'b0, 2'b00), 1'b1, 1'b0);
    repeat (3) idle(1'b1);

    // Single-instruction taken packet followed by its target.
    step(1'b1, mk(32'h1c000004, 32'h1c000100, 1'b1, 2'b00), 1'b1, 1'b0);
    step(1'b1, mk(32'h1c000100, 32'h1c000108, 1'b0, 2'b00), 1'b1, 1'b0);
    repeat (3) idle(1'b1);

    // Exception on inst0: issues alone, inst1 follows from the half-consumed head.
    step(1'b1, mk(32'h1c000200, 32'h1c000208, 1'b0, 2'b01), 1'b1, 1'b0);
    repeat (3) idle(1'b1);

    // Fill to full with ID stalled; the ninth write must be dropped.
    repeat (9) step(1'b1, rnd_pkt(), 1'b0, 1'b0);
    idle(1'b0);
    repeat (20) idle(1'b1);

    // Flush colliding with a write and a pop.
    step(1'b1, rnd_pkt(), 1'b0, 1'b0);
    step(1'b1, rnd_pkt(), 1'b0, 1'b0);
    step(1'b1, rnd_pkt(), 1'b1, 1'b1);
    idle(1'b1);

    // Asynchronous reset with packets in flight, then a fresh packet.
    repeat (3) step(1'b1, rnd_pkt(), 1'b0, 1'b0);
    async_reset();
    step(1'b1, mk(32'h1c000300, 32'h1c000308, 1'b0, 2'b00), 1'b1, 1'b0);
    repeat (3) idle(1'b1);

    // Random traffic across many pointer wraps.
    for (int c = 0; c < 500; c++) begin
      step(($urandom % 10) < 6, rnd_pkt(), ($urandom % 10) < 6, ($urandom % 150) == 0);
    end
    repeat (30) idle(1'b1);
    chk("drain_empty", 32'(expq.size()), 32'd0);

    @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
